// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the 5-stage pipeline run controller:
//   - state_e           : FSM state encodings (also driven on the state port)
//   - FLUSH_CYC_DEFAULT : default number of cycles to clear/drain the pipe
//   - CNT_W_DEFAULT     : default performance counter width
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_HALTED = 3'd1,
      ST_RUN    = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_STEP   = 3'd4
   } state_e;

   localparam int FLUSH_CYC_DEFAULT = 4;
   localparam int CNT_W_DEFAULT     = 32;

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter
// Free-running up-counter that advances by one on each clock with inc=1
// and wraps modulo 2^WL.
// Ports:
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset, clears the count
//   inc   : count enable
//   count : current count value (WL bits)
module wrap_counter #(
   parameter int WL = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          inc,
   output logic [WL-1:0] count
);

   logic [WL-1:0] count_q;
   logic [WL-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc) begin
         count_d = count_q + WL'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl
// Run/halt/single-step controller for a 5-stage pipeline. A Moore FSM
// (INIT, HALTED, RUN, DRAIN, STEP) gates the PC, kills fetches and clears
// the pipe registers; two wrap counters track active cycles and retired
// instructions.
// Ports:
//   CLK, RST      : clock and synchronous active-high reset
//   run_req       : start free-running execution (HALTED only)
//   step_req      : execute one instruction (HALTED only)
//   halt_req      : external halt (RUN only)
//   halt_instr    : halt opcode in decode (RUN only)
//   hz_stall      : hazard stall, PC and ID register must hold
//   wb_valid      : a real instruction writes back this cycle
//   pc_en         : PC register enable
//   fetch_kill    : inject a bubble into the ID pipe register
//   pipe_flush    : clear ID/EX/MEM/WB pipe registers
//   halted, busy  : status flags
//   state         : current FSM state encoding
//   cycle_cnt     : active (RUN/STEP/DRAIN) cycle count
//   retire_cnt    : retired instruction count
module pipe_run_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYC = FLUSH_CYC_DEFAULT,
   parameter int CNT_W     = CNT_W_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             run_req,
   input  logic             step_req,
   input  logic             halt_req,
   input  logic             halt_instr,
   input  logic             hz_stall,
   input  logic             wb_valid,
   output logic             pc_en,
   output logic             fetch_kill,
   output logic             pipe_flush,
   output logic             halted,
   output logic             busy,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt
);

   // Down-counter wide enough to hold FLUSH_CYC-1 (at least one bit).
   localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYC - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic fsm_pc_en, fsm_fetch_kill, fsm_pipe_flush, fsm_halted, fsm_busy;
   logic stop_req;
   logic cycle_inc, retire_inc;

   assign stop_req = halt_req | halt_instr;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      fsm_pc_en      = 1'b0;
      fsm_fetch_kill = 1'b1;
      fsm_pipe_flush = 1'b0;
      fsm_halted     = 1'b0;
      fsm_busy       = 1'b0;

      case (state_q)
         ST_INIT: begin
            fsm_pipe_flush = 1'b1;
            fsm_busy       = 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_HALTED;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         ST_HALTED: begin
            fsm_halted = 1'b1;
            if (run_req) begin
               state_d = ST_RUN;
            end else if (step_req) begin
               state_d = ST_STEP;
            end
         end

         ST_RUN: begin
            // A halt request blocks the PC and bubbles the fetch in the
            // same cycle so nothing past the halt point enters ID.
            fsm_pc_en      = ~hz_stall & ~stop_req;
            fsm_fetch_kill = stop_req;
            if (stop_req) begin
               state_d = ST_DRAIN;
               cnt_d   = FLUSH_LOAD;
            end
         end

         ST_STEP: begin
            // Let exactly one instruction into ID; wait out any stall.
            fsm_busy       = 1'b1;
            fsm_pc_en      = ~hz_stall;
            fsm_fetch_kill = 1'b0;
            if (!hz_stall) begin
               state_d = ST_DRAIN;
               cnt_d   = FLUSH_LOAD;
            end
         end

         ST_DRAIN: begin
            // A stall means the pipe is not advancing, so the drain
            // countdown pauses with it.
            fsm_busy = 1'b1;
            if (!hz_stall) begin
               if (cnt_q == '0) begin
                  state_d = ST_HALTED;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end

         default: begin
            state_d = ST_INIT;
            cnt_d   = FLUSH_LOAD;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_INIT;
         cnt_q   <= FLUSH_LOAD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // While RST is held the outputs already look like INIT, even before the
   // first edge has loaded the state register.
   always_comb begin
      pc_en      = fsm_pc_en;
      fetch_kill = fsm_fetch_kill;
      pipe_flush = fsm_pipe_flush;
      halted     = fsm_halted;
      busy       = fsm_busy;
      state      = state_q;
      if (RST) begin
         pc_en      = 1'b0;
         fetch_kill = 1'b1;
         pipe_flush = 1'b1;
         halted     = 1'b0;
         busy       = 1'b1;
         state      = ST_INIT;
      end
   end

   assign cycle_inc  = (state_q == ST_RUN) || (state_q == ST_STEP) ||
                       (state_q == ST_DRAIN);
   assign retire_inc = wb_valid && (state_q != ST_INIT);

   wrap_counter #(.WL(CNT_W)) u_cycle_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (cycle_inc),
      .count (cycle_cnt)
   );

   wrap_counter #(.WL(CNT_W)) u_retire_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (retire_inc),
      .count (retire_cnt)
   );

endmodule

// File: tb/tb_pipe_run_ctrl.sv
module tb_pipe_run_ctrl;

   logic CLK = 1'b0;
   logic RST, run_req, step_req, halt_req, halt_instr, hz_stall, wb_valid;

   logic        pc_en, fetch_kill, pipe_flush, halted, busy;
   logic [2:0]  state;
   logic [31:0] cycle_cnt, retire_cnt;

   logic        pc_en4, fetch_kill4, pipe_flush4, halted4, busy4;
   logic [2:0]  state4;
   logic [3:0]  cycle_cnt4, retire_cnt4;

   int n_total = 0;
   int n_pass  = 0;

   always #5 CLK = ~CLK;

   pipe_run_ctrl dut (
      .CLK(CLK), .RST(RST), .run_req(run_req), .step_req(step_req),
      .halt_req(halt_req), .halt_instr(halt_instr), .hz_stall(hz_stall),
      .wb_valid(wb_valid), .pc_en(pc_en), .fetch_kill(fetch_kill),
      .pipe_flush(pipe_flush), .halted(halted), .busy(busy), .state(state),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
   );

   pipe_run_ctrl #(.FLUSH_CYC(4), .CNT_W(4)) dut4 (
      .CLK(CLK), .RST(RST), .run_req(run_req), .step_req(step_req),
      .halt_req(halt_req), .halt_instr(halt_instr), .hz_stall(hz_stall),
      .wb_valid(wb_valid), .pc_en(pc_en4), .fetch_kill(fetch_kill4),
      .pipe_flush(pipe_flush4), .halted(halted4), .busy(busy4),
      .state(state4), .cycle_cnt(cycle_cnt4), .retire_cnt(retire_cnt4)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Advance one clock; sampling happens 1 time unit after the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
      halt_instr = 1'b0; hz_stall = 1'b0; wb_valid = 1'b0;

      // ---- outputs while RST is held, then release ----
      #1;
      chk("rst_flush", pipe_flush, 1);
      chk("rst_pc_en", pc_en, 0);
      chk("rst_kill", fetch_kill, 1);
      chk("rst_halted", halted, 0);
      chk("rst_busy", busy, 1);
      chk("rst_state", state, 0);
      tick(); tick();
      chk("rst_cycle", cycle_cnt, 0);
      chk("rst_retire", retire_cnt, 0);
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("init_flush%0d", i), pipe_flush, 1);
         chk($sformatf("init_state%0d", i), state, 0);
         tick();
      end
      chk("init_done_state", state, 1);
      chk("init_done_halted", halted, 1);
      chk("init_done_flush", pipe_flush, 0);
      chk("init_done_cycle", cycle_cnt, 0);
      chk("init_done_retire", retire_cnt, 0);
      $display("txn reset_release state=%0d", state);

      // ---- RUN with two stall cycles ----
      chk("halted_pc_en", pc_en, 0);
      chk("halted_kill", fetch_kill, 1);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      chk("run_state", state, 2);
      chk("run_pc_en0", pc_en, 1);
      chk("run_cycle0", cycle_cnt, 0);
      tick();
      hz_stall = 1'b1; #1;
      chk("run_pc_en1", pc_en, 0);
      chk("run_cycle1", cycle_cnt, 1);
      tick();
      chk("run_pc_en2", pc_en, 0);
      chk("run_cycle2", cycle_cnt, 2);
      hz_stall = 1'b0; #1;
      chk("run_pc_en3", pc_en, 1);
      tick();
      chk("run_cycle3", cycle_cnt, 3);
      $display("txn run_stall cycle_cnt=%0d", cycle_cnt);

      // ---- halt via halt_instr ----
      halt_instr = 1'b1; #1;
      chk("hi_pc_en", pc_en, 0);
      chk("hi_kill", fetch_kill, 1);
      chk("hi_state_run", state, 2);
      tick();
      halt_instr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("hi_drain%0d", i), state, 3);
         chk($sformatf("hi_drain_pc%0d", i), pc_en, 0);
         tick();
      end
      chk("hi_halted", state, 1);
      chk("hi_cycle", cycle_cnt, 8);
      $display("txn halt_instr state=%0d cycle_cnt=%0d", state, cycle_cnt);

      // ---- single step with one writeback during DRAIN ----
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      chk("st_state", state, 4);
      chk("st_pc_en", pc_en, 1);
      chk("st_busy", busy, 1);
      tick();
      chk("st_drain0", state, 3);
      wb_valid = 1'b1;
      tick();
      wb_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         chk($sformatf("st_drain%0d", i), state, 3);
         tick();
      end
      chk("st_halted", state, 1);
      chk("st_retire", retire_cnt, 1);
      chk("st_cycle", cycle_cnt, 13);
      $display("txn single_step retire_cnt=%0d", retire_cnt);

      // ---- step held by a stall ----
      step_req = 1'b1; hz_stall = 1'b1;
      tick();
      step_req = 1'b0;
      chk("sts_state0", state, 4);
      chk("sts_pc_en0", pc_en, 0);
      tick();
      chk("sts_state1", state, 4);
      hz_stall = 1'b0; #1;
      chk("sts_pc_en1", pc_en, 1);
      tick();
      chk("sts_drain", state, 3);
      for (int i = 0; i < 4; i++) tick();
      chk("sts_halted", state, 1);
      $display("txn step_stall state=%0d", state);

      // ---- run wins over step; halt_req; stall pauses DRAIN ----
      run_req = 1'b1; step_req = 1'b1;
      tick();
      run_req = 1'b0;
      chk("prio_state", state, 2);
      tick();
      chk("step_ignored_run", state, 2);
      step_req = 1'b0;
      halt_req = 1'b1; #1;
      chk("hr_kill", fetch_kill, 1);
      chk("hr_pc_en", pc_en, 0);
      tick();
      halt_req = 1'b0;
      chk("hr_drain", state, 3);
      hz_stall = 1'b1;
      tick(); tick(); tick(); tick();
      chk("drain_stalled", state, 3);
      hz_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain_resume%0d", i), state, 3);
         tick();
      end
      chk("drain_done", state, 1);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("hr_ignored_halted", state, 1);
      $display("txn halt_req state=%0d", state);

      // ---- reset in the middle of DRAIN ----
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      tick();
      chk("rd_in_drain", state, 3);
      RST = 1'b1; #1;
      chk("rd_rst_state_comb", state, 0);
      tick();
      chk("rd_state", state, 0);
      chk("rd_flush", pipe_flush, 1);
      chk("rd_cycle", cycle_cnt, 0);
      chk("rd_retire", retire_cnt, 0);
      RST = 1'b0;
      $display("txn reset_in_drain state=%0d", state);

      // ---- 4-bit counter wrap after 16 RUN cycles ----
      for (int i = 0; i < 4; i++) tick();
      chk("wr_halted", state4, 1);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      chk("wr_start", cycle_cnt4, 0);
      for (int i = 0; i < 15; i++) tick();
      chk("wr_15", cycle_cnt4, 15);
      tick();
      chk("wr_0", cycle_cnt4, 0);
      chk("wr_wide16", cycle_cnt, 16);
      $display("txn counter_wrap cycle_cnt4=%0d", cycle_cnt4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipe_run_ctrl.md
PIPE_RUN_CTRL -- requirements
Module: pipe_run_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYC, default 4: cycles needed to clear or drain the 5-stage pipeline (minimum 1).
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port CLK, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port run_req, input, 1: start free-running execution; sampled only in HALTED.
REQ-006 SHALL have port step_req, input, 1: execute exactly one instruction; sampled only in HALTED.
REQ-007 SHALL have port halt_req, input, 1: external halt request; sampled only in RUN.
REQ-008 SHALL have port halt_instr, input, 1: decode stage holds a halt opcode; sampled only in RUN.
REQ-009 SHALL have port hz_stall, input, 1: hazard-unit stall, high means the PC and ID register must hold.
REQ-010 SHALL have port wb_valid, input, 1: a non-bubble instruction writes back this cycle.
REQ-011 SHALL have port pc_en, output, 1: PC register enable.
REQ-012 SHALL have port fetch_kill, output, 1: inject a bubble into the ID pipe register.
REQ-013 SHALL have port pipe_flush, output, 1: clear all pipe registers (ID/EX/MEM/WB).
REQ-014 SHALL have port halted, output, 1: high when the controller is in HALTED.
REQ-015 SHALL have port busy, output, 1: high in INIT, STEP or DRAIN.
REQ-016 SHALL have port state, output, 3: current FSM state encoding.
REQ-017 SHALL have port cycle_cnt, output, CNT_W: count of active cycles.
REQ-018 SHALL have port retire_cnt, output, CNT_W: count of retired instructions.

Function
REQ-019 SHALL implement a Moore FSM with these encodings: INIT=0, HALTED=1, RUN=2, DRAIN=3, STEP=4.
REQ-020 SHALL behave in INIT as follows:
- pipe_flush=1, pc_en=0, fetch_kill=1.
- Down-counter starts at FLUSH_CYC-1 and decrements each cycle.
- At 0, the next state is HALTED.
REQ-021 SHALL behave in HALTED as follows:
- pc_en=0, fetch_kill=1, halted=1.
- run_req goes to RUN.
- Otherwise step_req goes to STEP.
- run_req wins if both are asserted.
REQ-022 SHALL, in RUN, drive pc_en = ~hz_stall & ~halt_req & ~halt_instr and fetch_kill = halt_req | halt_instr; these outputs are combinational on the inputs.
REQ-023 SHALL, in RUN, go to DRAIN when halt_req or halt_instr is asserted, loading the counter with FLUSH_CYC-1.
REQ-024 SHALL, in STEP, drive pc_en = ~hz_stall and stay in STEP while hz_stall=1; on the first cycle with hz_stall=0 it goes to DRAIN and loads the counter.
REQ-025 SHALL, in DRAIN, drive pc_en=0 and fetch_kill=1; the counter decrements only when hz_stall=0, and at counter 0 with hz_stall=0 the next state is HALTED.
REQ-026 SHALL ignore step_req in RUN, ignore halt_req and run_req outside their sampling states, and ignore run_req deassertion.
REQ-027 SHALL increment cycle_cnt every cycle in RUN, STEP or DRAIN; it wraps modulo 2^CNT_W.
REQ-028 SHALL increment retire_cnt on wb_valid=1 in any state except INIT; it wraps modulo 2^CNT_W.
REQ-029 SHALL hold pipe_flush=0 in every state except INIT.

Reset
REQ-030 SHALL, on RST=1 at a clock edge, set state=INIT, counter=FLUSH_CYC-1, cycle_cnt=0 and retire_cnt=0, regardless of current state.
REQ-031 SHALL present these output values while in reset and in INIT: pipe_flush=1, pc_en=0, fetch_kill=1, halted=0, busy=1, state=0.
REQ-032 SHALL give RST priority over every other input, including in the middle of DRAIN or STEP.

Structure
REQ-033 SHALL take state encodings and the FLUSH_CYC default from shared package pipe_ctrl_pkg.
REQ-034 SHALL instantiate sub-module wrap_counter (parameter WL, inputs CLK, RST, inc; output count) twice, once for cycle_cnt and once for retire_cnt.

Verification (FLUSH_CYC=4)
REQ-035 SHALL verify release from reset:
- Stimulus: RST high for 2 cycles, then low.
- Response: pipe_flush high for exactly 4 cycles, then state=1, halted=1, both counters 0.
REQ-036 SHALL verify RUN with stalls:
- Stimulus: from HALTED, run_req pulse, then hz_stall high for 2 cycles.
- Response: state=2 next cycle; pc_en 1,0,0,1; cycle_cnt increments through the stalls.
REQ-037 SHALL verify halt via halt_instr:
- Stimulus: in RUN, halt_instr pulse.
- Response: same cycle pc_en=0 and fetch_kill=1; state=3 for 4 cycles; then state=1.
REQ-038 SHALL verify single step:
- Stimulus: from HALTED, step_req pulse, plus one wb_valid pulse during DRAIN.
- Response: state=4 with pc_en=1 for one cycle; DRAIN for 4 cycles; HALTED; retire_cnt=1.
REQ-039 SHALL verify counter wrap:
- Stimulus: CNT_W=4, 16 cycles in RUN.
- Response: cycle_cnt wraps from 15 to 0.
REQ-040 SHALL verify reset during DRAIN:
- Stimulus: RST asserted for one cycle while in DRAIN.
- Response: next edge state=0, pipe_flush=1, counters 0.
